mult_error_sweep: RTL and testbench
===================================

Name: mult_error_sweep

Overview:
- Exhaustive evaluation stage that sits around one candidate WIDTHxWIDTH multiplier generated by the NSGA flow.
- Upstream role: it sweeps every operand pair into the multiplier under test.
- Downstream role: it consumes the product the multiplier returns, compares it against an internal exact product, and accumulates error metrics.
- The metrics (error count, summed error distance, max error distance plus the operand pair that produced it) are the per-candidate fitness figures for the optimiser.

Parameters:
- WIDTH, 4, operand width of the multiplier under test; sweep length is 2^(2*WIDTH) pairs.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- op_a  output  WIDTH  operand A to the multiplier under test.
- op_b  output  WIDTH  operand B to the multiplier under test.
- prod_in  input  2*WIDTH  product returned combinationally by the multiplier under test for the current op_a/op_b.
- busy  output  1  high while a sweep or drain is in progress.
- done  output  1  one-cycle pulse; results are final.
- err_count  output  2*WIDTH+1  number of pairs with prod_in != exact product.
- sum_ed  output  4*WIDTH  sum of |prod_in - A*B| over all pairs.
- max_ed  output  2*WIDTH  largest |prod_in - A*B| seen.
- max_a  output  WIDTH  op_a of the first pair reaching max_ed.
- max_b  output  WIDTH  op_b of the first pair reaching max_ed.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - Index counter, pipeline register, busy, done, err_count, sum_ed, max_ed, max_a and max_b all become 0.
  - Reset mid-sweep aborts the sweep and discards all partial results.
- States:
  - IDLE: start=1 clears all accumulators, sets idx=0, goes to SWEEP.
  - SWEEP: op_a=idx[2W-1:W], op_b=idx[W-1:0]; each edge captures {op_a, op_b, prod_in} into the pipe register and increments idx. The edge that captures idx=2^(2W)-1 goes to DRAIN; idx wraps to 0.
  - DRAIN: accumulates the final captured pair, then goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- op_a/op_b: equal to idx fields in SWEEP, held at 0 in all other states.
- Pipeline (one stage):
  - A pair captured at edge n is accumulated at edge n+1.
  - The pipe valid bit is set in SWEEP and clear otherwise.
  - Accumulation happens only when pipe valid is set.
- Error distance: ed = |prod_in_q - a_q*b_q|.
  - Exact product is computed internally at 2*WIDTH bits, unsigned.
  - The difference is taken at 2*WIDTH+1 bits, then magnitude; the result fits 2*WIDTH bits.
  - ed != 0 increments err_count.
  - sum_ed += ed. Width 4*WIDTH cannot overflow; no saturation logic.
  - Strictly greater ed replaces max_ed and updates max_a/max_b. Ties keep the earlier pair (first occurrence in idx order).
- Timing, with start sampled at edge 0:
  - busy=1 in cycles 1 .. 2^(2W)+1 (SWEEP then DRAIN).
  - done=1 in cycle 2^(2W)+2; for WIDTH=4, sweep is cycles 1..256, DRAIN is cycle 257, done is cycle 258.
- Result outputs:
  - Registered, and held stable from done until the next accepted start or reset.
  - Intermediate values are visible during the sweep but are not meaningful until done.
- start handling:
  - start while busy or in DONE is ignored, with no restart and no accumulator clear.
  - start held high continuously triggers a new sweep on the first IDLE cycle after DONE.
- prod_in is assumed stable within the cycle. Any 2*WIDTH-bit value, including values greater than the max exact product, is handled without special cases.

Test Plan:
- Exact multiplier (prod_in = op_a*op_b), WIDTH=4, pulse start -> busy cycles 1..257, done cycle 258; err_count=0, sum_ed=0, max_ed=0, max_a=0, max_b=0.
- prod_in tied to 0 -> err_count=225, sum_ed=14400, max_ed=225, max_a=15, max_b=15.
- prod_in = exact|1 (LSB stuck-at-1) -> err_count=192, sum_ed=192, max_ed=1, max_a=0, max_b=0 (tie rule keeps first pair).
- prod_in = exact except 8'hFF at op_a=3, op_b=5 -> err_count=1, sum_ed=240, max_ed=240, max_a=3, max_b=5.
- start re-pulsed at cycle 100 -> ignored; done still at cycle 258 with correct totals. rst_n=0 at cycle 120 -> next cycle all outputs 0, state IDLE, busy=0, and no done pulse follows.
- Back-to-back: start held high through two sweeps with first run all-zero prod_in and second run exact -> second done shows all metrics 0 (accumulators cleared on restart).

Source files
------------

// File: rtl/mult_error_sweep_if.sv
// Operand/product bus between the sweep engine and the multiplier under test.
// master drives op_a/op_b and receives prod_in; slave is the multiplier side.
interface mult_error_sweep_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] prod_in;

  modport master (
    output op_a,
    output op_b,
    input  prod_in
  );

  modport slave (
    input  op_a,
    input  op_b,
    output prod_in
  );
endinterface

// File: rtl/mult_error_sweep.sv
// Exhaustive error sweep of one candidate multiplier: drives all operand pairs,
// accumulates err_count/sum_ed/max_ed(+pair); busy/done report progress.
module mult_error_sweep #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  mult_error_sweep_if.master   mul,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH:0]     err_count,
  output logic [4*WIDTH-1:0]   sum_ed,
  output logic [2*WIDTH-1:0]   max_ed,
  output logic [WIDTH-1:0]     max_a,
  output logic [WIDTH-1:0]     max_b
);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PW-1:0]    r_idx;
  logic             r_pv;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_p;
  logic [PW:0]      r_err;
  logic [2*PW-1:0]  r_sum;
  logic [PW-1:0]    r_max;
  logic [WIDTH-1:0] r_max_a;
  logic [WIDTH-1:0] r_max_b;

  logic             w_sweep;
  logic             w_last;
  logic [PW-1:0]    w_exact;
  logic [PW:0]      w_diff;
  logic [PW-1:0]    w_ed;

  assign w_sweep = (r_state == S_SWEEP);
  assign w_last  = (r_idx == {PW{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SWEEP;
      S_SWEEP: if (w_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = w_sweep || (r_state == S_DRAIN);
    done     = (r_state == S_DONE);
    mul.op_a = '0;
    mul.op_b = '0;
    if (w_sweep) begin
      mul.op_a = r_idx[PW-1:WIDTH];
      mul.op_b = r_idx[WIDTH-1:0];
    end
  end

  // Diff at PW+1 bits; the magnitude always fits PW bits, so the
  // negative case is the two's complement of the low bits.
  assign w_exact = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
  assign w_diff  = {1'b0, r_p} - {1'b0, w_exact};
  assign w_ed    = w_diff[PW] ? (~w_diff[PW-1:0] + PW'(1))
                              : w_diff[PW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_pv    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_err   <= '0;
      r_sum   <= '0;
      r_max   <= '0;
      r_max_a <= '0;
      r_max_b <= '0;
    end else begin
      r_pv <= w_sweep;
      if ((r_state == S_IDLE) && start) begin
        r_idx   <= '0;
        r_err   <= '0;
        r_sum   <= '0;
        r_max   <= '0;
        r_max_a <= '0;
        r_max_b <= '0;
      end
      if (w_sweep) begin
        r_a   <= mul.op_a;
        r_b   <= mul.op_b;
        r_p   <= mul.prod_in;
        r_idx <= r_idx + PW'(1);
      end
      if (r_pv) begin
        r_err <= r_err + (PW+1)'(w_ed != '0);
        r_sum <= r_sum + (2*PW)'(w_ed);
        // Strict compare: ties keep the earliest pair.
        if (w_ed > r_max) begin
          r_max   <= w_ed;
          r_max_a <= r_a;
          r_max_b <= r_b;
        end
      end
    end
  end

  assign err_count = r_err;
  assign sum_ed    = r_sum;
  assign max_ed    = r_max;
  assign max_a     = r_max_a;
  assign max_b     = r_max_b;
endmodule

// File: tb/tb_mult_error_sweep.sv
// Directed bench for mult_error_sweep (WIDTH=4) with a behavioural
// multiplier whose fault mode is selected per scenario.
module tb_mult_error_sweep;
  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [8:0]  err_count;
  logic [15:0] sum_ed;
  logic [7:0]  max_ed;
  logic [3:0]  max_a;
  logic [3:0]  max_b;
  int          mode = 0;
  int          total = 0;
  int          bad = 0;

  mult_error_sweep_if #(.WIDTH(W)) mif ();

  mult_error_sweep #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mul       (mif),
    .busy      (busy),
    .done      (done),
    .err_count (err_count),
    .sum_ed    (sum_ed),
    .max_ed    (max_ed),
    .max_a     (max_a),
    .max_b     (max_b)
  );

  always #5 clk = ~clk;

  logic [7:0] exact;
  always_comb begin
    exact = 8'(mif.op_a) * 8'(mif.op_b);
    case (mode)
      1: mif.prod_in = 8'h00;
      2: mif.prod_in = exact | 8'h01;
      3: mif.prod_in = (mif.op_a == 4'd3 && mif.op_b == 4'd5)
                       ? 8'hFF : exact;
      default: mif.prod_in = exact;
    endcase
  end

  // Pulse start (sampled at edge 0), then watch cycles 1..262.
  // Counts busy/done deviations from the expected 1..257 / 258 window.
  task automatic run_sweep(input int md, input int repulse,
                           output int busy_bad, output int done_cyc,
                           output int done_n);
    mode = md;
    busy_bad = 0;
    done_cyc = -1;
    done_n = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 262; c++) begin
      start = (c == repulse);
      @(negedge clk);
      if (busy !== (c <= 257)) busy_bad++;
      if (done === 1'b1) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, err_count, sum_ed, max_ed, max_a, max_b,
         mif.op_a, mif.op_b} !== '0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b err=%0d sum=%0d max=%0d a=%0d b=%0d opa=%0d opb=%0d, want all 0",
               busy, done, err_count, sum_ed, max_ed, max_a, max_b,
               mif.op_a, mif.op_b);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_metrics(input string nm, input int e, input int s,
                               input int m, input int a, input int b);
    total++;
    if (err_count !== 9'(e) || sum_ed !== 16'(s) || max_ed !== 8'(m)
        || max_a !== 4'(a) || max_b !== 4'(b)) begin
      bad++;
      $display("FAIL %s: err=%0d sum=%0d max=%0d a=%0d b=%0d, want %0d %0d %0d %0d %0d",
               nm, err_count, sum_ed, max_ed, max_a, max_b, e, s, m, a, b);
    end
  endtask

  task automatic test_exact;
    int bb, dc, dn;
    run_sweep(0, -1, bb, dc, dn);
    total++;
    if (bb !== 0) begin
      bad++;
      $display("FAIL exact_busy: %0d wrong cycles, want 0", bb);
    end
    total++;
    if (dc !== 258 || dn !== 1) begin
      bad++;
      $display("FAIL exact_done: cycle=%0d pulses=%0d, want 258 1", dc, dn);
    end
    total++;
    if ({err_count, sum_ed, max_ed, max_a, max_b} !== '0) begin
      bad++;
      $display("FAIL exact_metrics: err=%0d sum=%0d max=%0d a=%0d b=%0d, want 0",
               err_count, sum_ed, max_ed, max_a, max_b);
    end
  endtask

  task automatic test_zero;
    int bb, dc, dn;
    run_sweep(1, -1, bb, dc, dn);
    total++;
    if (dc !== 258) begin
      bad++;
      $display("FAIL zero_done: cycle=%0d, want 258", dc);
    end
    total++;
    if (err_count !== 9'd225 || sum_ed !== 16'd14400) begin
      bad++;
      $display("FAIL zero_totals: err=%0d sum=%0d, want 225 14400",
               err_count, sum_ed);
    end
    total++;
    if (max_ed !== 8'd225 || max_a !== 4'd15 || max_b !== 4'd15) begin
      bad++;
      $display("FAIL zero_max: max=%0d a=%0d b=%0d, want 225 15 15",
               max_ed, max_a, max_b);
    end
  endtask

  task automatic test_lsb_stuck;
    int bb, dc, dn;
    run_sweep(2, -1, bb, dc, dn);
    check_metrics("lsb_stuck", 192, 192, 1, 0, 0);
  endtask

  task automatic test_single_fault;
    int bb, dc, dn;
    run_sweep(3, -1, bb, dc, dn);
    check_metrics("single_fault", 1, 240, 240, 3, 5);
  endtask

  task automatic test_restart_ignored;
    int bb, dc, dn;
    run_sweep(1, 100, bb, dc, dn);
    total++;
    if (bb !== 0 || dc !== 258 || dn !== 1) begin
      bad++;
      $display("FAIL restart_timing: busybad=%0d done=%0d pulses=%0d, want 0 258 1",
               bb, dc, dn);
    end
    check_metrics("restart_totals", 225, 14400, 225, 15, 15);
  endtask

  task automatic test_abort;
    int dn = 0;
    int busy_after = 0;
    mode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 262; c++) begin
      rst_n = (c != 120);
      @(negedge clk);
      if (c == 119) begin
        total++;
        if (busy !== 1'b1 || err_count === 9'd0) begin
          bad++;
          $display("FAIL abort_pre: busy=%b err=%0d, want 1 nonzero",
                   busy, err_count);
        end
      end
      if (c == 121) begin
        total++;
        if ({busy, done, err_count, sum_ed, max_ed, max_a, max_b,
             mif.op_a, mif.op_b} !== '0) begin
          bad++;
          $display("FAIL abort_clear: busy=%b err=%0d sum=%0d max=%0d a=%0d b=%0d, want 0",
                   busy, err_count, sum_ed, max_ed, max_a, max_b);
        end
      end
      if (c > 121) begin
        if (done === 1'b1) dn++;
        if (busy === 1'b1) busy_after++;
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    total++;
    if (dn !== 0 || busy_after !== 0) begin
      bad++;
      $display("FAIL abort_quiet: done pulses=%0d busy cycles=%0d, want 0 0",
               dn, busy_after);
    end
  endtask

  task automatic test_back_to_back;
    int d1 = -1;
    int d2 = -1;
    mode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 530 && d2 < 0; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (d1 < 0) begin
          d1 = c;
          check_metrics("b2b_first", 225, 14400, 225, 15, 15);
          mode = 0;
        end else begin
          d2 = c;
          check_metrics("b2b_second", 0, 0, 0, 0, 0);
          start = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    total++;
    if (d1 !== 258 || d2 !== 517) begin
      bad++;
      $display("FAIL b2b_done: cycles=%0d %0d, want 258 517", d1, d2);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset;
    test_exact;
    test_zero;
    test_lsb_stuck;
    test_single_fault;
    test_restart_ignored;
    test_abort;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
